uart_program_loader: RTL and testbench

Boot-time loader upstream of the CPU core. Receives a framed program image as a byte stream from the UART receiver, packs it little-endian into 64-bit words, and writes them into main memory over an AXI4-Lite write master. Holds the core in reset until the image is written and its checksum has passed, then releases it.

---
 rtl/uart_program_loader.sv | 195 +++++++++++++++++++
 tb/tb_uart_program_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// Boot loader: unpacks a MAGIC/LEN/payload/CHK byte frame into little-endian 64-bit words,
// writes them over AXI4-Lite and releases the core once the image and its checksum are good.
module uart_program_loader #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned MAX_BYTES = 65536,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [63:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_error
);
    typedef enum logic [3:0] {IDLE, LEN0, LEN1, LEN2, LEN3, PAYLOAD, CHK, DRAIN, RUN} state_t;
    localparam logic [31:0] MAX_LEN = 32'(MAX_BYTES);

    state_t      state_q, state_d;
    logic [31:0] len_q, cnt_q, len_full;
    logic [7:0]  xor_q, chk_q;
    logic [63:0] pack_q, lane_word;
    logic [28:0] widx_q;
    logic [2:0]  lane;
    logic        stage_vld_q;
    logic [63:0] stage_data_q, stage_addr_q;
    logic [7:0]  stage_strb_q;
    logic [63:0] fifo_data_q [2];
    logic [63:0] fifo_addr_q [2];
    logic [7:0]  fifo_strb_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q;
    logic        aw_done_q, w_done_q, flush_q, wr_err_q;
    logic        done_q, err_q, core_rst_q;
    logic        pay_byte, last_byte, word_done, len_shift, len_bad;
    logic        busy, pop, overflow, push_ok, drain_ok, pass;
    logic        start, set_err, set_done;

    assign len_full  = {rx_byte, len_q[31:8]};
    assign lane      = cnt_q[2:0];
    assign lane_word = {56'd0, rx_byte} << {lane, 3'd0};
    assign len_shift = rx_valid && (state_q inside {LEN0, LEN1, LEN2, LEN3});
    assign len_bad   = rx_valid && (state_q == LEN3) && (len_full > MAX_LEN);
    assign pay_byte  = rx_valid && (state_q == PAYLOAD);
    assign last_byte = pay_byte && (cnt_q + 32'd1 == len_q);
    assign word_done = pay_byte && ((lane == 3'd7) || last_byte);
    assign busy      = (count_q != 2'd0);
    assign pop       = bvalid && busy;
    assign overflow  = stage_vld_q && (count_q == 2'd2) && !pop;
    assign push_ok   = stage_vld_q && !overflow;
    assign drain_ok  = (state_q == DRAIN) && !stage_vld_q && !busy && !flush_q;
    assign pass      = (chk_q == xor_q) && !wr_err_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (overflow) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (rx_valid && rx_byte == MAGIC) state_d = LEN0;
                LEN0:    if (rx_valid) state_d = LEN1;
                LEN1:    if (rx_valid) state_d = LEN2;
                LEN2:    if (rx_valid) state_d = LEN3;
                LEN3:    if (rx_valid) begin
                             if (len_full > MAX_LEN)      state_d = IDLE;
                             else if (len_full == 32'd0)  state_d = CHK;
                             else                         state_d = PAYLOAD;
                         end
                PAYLOAD: if (last_byte) state_d = CHK;
                CHK:     if (rx_valid) state_d = DRAIN;
                DRAIN:   if (drain_ok) state_d = pass ? RUN : IDLE;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        start    = (state_q == IDLE) && rx_valid && (rx_byte == MAGIC) && !overflow;
        set_err  = overflow || len_bad || (drain_ok && !pass);
        set_done = drain_ok && pass && !overflow;
    end

    // Packer: a completed word is staged here and enters the FIFO on the following cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            cnt_q  <= '0;
            xor_q  <= '0;
            pack_q <= '0;
            widx_q <= '0;
        end
        if (len_shift) len_q <= len_full;
        if (pay_byte) begin
            cnt_q <= cnt_q + 32'd1;
            xor_q <= xor_q ^ rx_byte;
            if (word_done) begin
                pack_q       <= '0;
                stage_data_q <= pack_q | lane_word;
                stage_strb_q <= 8'hFF >> (3'd7 - lane);
                stage_addr_q <= BASE_ADDR + {32'd0, widx_q, 3'd0};
                widx_q       <= widx_q + 29'd1;
            end else begin
                pack_q <= pack_q | lane_word;
            end
        end
        if (rx_valid && state_q == CHK) chk_q <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data_q[wr_ptr_q] <= stage_data_q;
            fifo_strb_q[wr_ptr_q] <= stage_strb_q;
            fifo_addr_q[wr_ptr_q] <= stage_addr_q;
        end
    end

    // The FIFO head is always the write in flight; it leaves only when its B response arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            flush_q     <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            stage_vld_q <= word_done && !overflow;
            if (pop) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (awvalid && awready) aw_done_q <= 1'b1;
                if (wvalid && wready)   w_done_q  <= 1'b1;
            end
            if (start)                         wr_err_q <= 1'b0;
            else if (pop && bresp != 2'b00)    wr_err_q <= 1'b1;
            if (pop && flush_q) begin
                flush_q  <= 1'b0;
                rd_ptr_q <= wr_ptr_q;
                wr_ptr_q <= wr_ptr_q ^ push_ok;
                count_q  <= {1'b0, push_ok};
            end else begin
                if (push_ok) wr_ptr_q <= ~wr_ptr_q;
                if (pop)     rd_ptr_q <= ~rd_ptr_q;
                count_q <= count_q + {1'b0, push_ok} - {1'b0, pop};
                if (overflow) flush_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            if (start) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (set_err) err_q <= 1'b1;
            if (set_done) begin
                done_q     <= 1'b1;
                core_rst_q <= 1'b0;
            end
        end
    end

    assign awvalid    = busy && !aw_done_q;
    assign wvalid     = busy && !w_done_q;
    assign awaddr     = busy ? fifo_addr_q[rd_ptr_q] : 64'd0;
    assign wdata      = busy ? fifo_data_q[rd_ptr_q] : 64'd0;
    assign wstrb      = busy ? fifo_strb_q[rd_ptr_q] : 8'd0;
    assign bready     = 1'b1;
    assign core_rst   = core_rst_q;
    assign load_done  = done_q;
    assign load_error = err_q;
endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed and random frames checked against a byte-level write model
// and an AXI slave whose ready/response behaviour is steered per test.
module tb_uart_program_loader;
    localparam logic [63:0] BASE  = 64'h0;
    localparam int          MAXB  = 65536;
    localparam logic [7:0]  MAGIC = 8'hA5;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic [63:0] awaddr, wdata;
    logic [7:0]  wstrb;
    logic        awvalid, wvalid, bready, core_rst, load_done, load_error;
    logic        awready = 1'b1;
    logic        wready = 1'b1;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    int  ready_mode = 0;
    int  hold_cycles = 0;
    bit  bresp_err_first = 1'b0;
    int  b_count = 0;
    bit  aw_hs, w_hs, aw_seen, w_seen, slv_aw, slv_w;

    uart_program_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB), .MAGIC(MAGIC)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .core_rst(core_rst), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic void check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endfunction

    // Monitor at negedge, slave update just after posedge
    initial begin
        forever begin
            @(negedge clk);
            aw_hs = 1'b0;
            w_hs  = 1'b0;
            if (!rst) begin
                check1("core_rst_vs_done", core_rst, !load_done);
                check1("bready", bready, 1'b1);
                if (exp_q.size() == 0) begin
                    check1("no_awvalid_expected", awvalid, 1'b0);
                    check1("no_wvalid_expected", wvalid, 1'b0);
                end else begin
                    if (awvalid) check64("awaddr", awaddr, exp_q[0].addr);
                    if (wvalid) begin
                        check64("wdata", wdata, exp_q[0].data);
                        check64("wstrb", {56'd0, wstrb}, {56'd0, exp_q[0].strb});
                    end
                end
                aw_hs = awvalid && awready;
                w_hs  = wvalid && wready;
                if (exp_q.size() != 0) begin
                    if (aw_hs) aw_seen = 1'b1;
                    if (w_hs)  w_seen  = 1'b1;
                    if (aw_seen && w_seen) begin
                        void'(exp_q.pop_front());
                        aw_seen = 1'b0;
                        w_seen  = 1'b0;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (rst) begin
                bvalid = 1'b0;
                slv_aw = 1'b0;
                slv_w  = 1'b0;
            end else begin
                if (bvalid) bvalid = 1'b0;
                if (aw_hs) slv_aw = 1'b1;
                if (w_hs)  slv_w  = 1'b1;
                if (slv_aw && slv_w) begin
                    bvalid = 1'b1;
                    bresp  = (bresp_err_first && b_count == 0) ? 2'b10 : 2'b00;
                    b_count++;
                    slv_aw = 1'b0;
                    slv_w  = 1'b0;
                end
            end
            case (ready_mode)
                1: begin
                    awready = ($urandom_range(0, 3) != 0);
                    wready  = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    if (hold_cycles > 0) begin
                        awready = 1'b0;
                        hold_cycles--;
                    end else begin
                        awready = 1'b1;
                    end
                    wready = 1'b1;
                end
                default: begin
                    awready = 1'b1;
                    wready  = 1'b1;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        check1({name, "_awvalid"}, awvalid, 1'b0);
        check1({name, "_wvalid"}, wvalid, 1'b0);
        check64({name, "_awaddr"}, awaddr, 64'd0);
        check64({name, "_wdata"}, wdata, 64'd0);
        check64({name, "_wstrb"}, {56'd0, wstrb}, 64'd0);
        check1({name, "_bready"}, bready, 1'b1);
        check1({name, "_core_rst"}, core_rst, 1'b1);
        check1({name, "_load_done"}, load_done, 1'b0);
        check1({name, "_load_error"}, load_error, 1'b0);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        rx_valid = 1'b0;
        exp_q.delete();
        aw_seen = 1'b0;
        w_seen  = 1'b0;
        slv_aw  = 1'b0;
        slv_w   = 1'b0;
        bvalid  = 1'b0;
        b_count = 0;
        ready_mode = 0;
        bresp_err_first = 1'b0;
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals(name);
    endtask

    function automatic bq_t rand_payload(input int n, input bit no_magic);
        bq_t q;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (no_magic && b == MAGIC) b = 8'h00;
            q.push_back(b);
        end
        return q;
    endfunction

    function automatic logic [7:0] xor_of(input bq_t p);
        logic [7:0] c = 8'h00;
        foreach (p[i]) c = c ^ p[i];
        return c;
    endfunction

    // Expected AXI writes: word w carries bytes 8w..8w+7, low byte in the low lane.
    task automatic model_writes(input bq_t p, input int max_words);
        wr_t e;
        for (int w = 0; w * 8 < p.size() && w < max_words; w++) begin
            e.addr = BASE + 64'(8 * w);
            e.data = 64'd0;
            e.strb = 8'd0;
            for (int k = 0; k < 8 && (w * 8 + k) < p.size(); k++) begin
                e.data = e.data | (64'(p[w * 8 + k]) << (8 * k));
                e.strb[k] = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic send_head(input int n);
        send(MAGIC);
        for (int k = 0; k < 4; k++) send(8'(n >> (8 * k)));
    endtask

    task automatic send_frame(input bq_t p, input bit bad, input int gap_max);
        logic [7:0] c;
        send_head(p.size());
        foreach (p[i]) begin
            send(p[i]);
            repeat ($urandom_range(0, gap_max)) tick();
        end
        c = xor_of(p);
        if (bad) c = ~c;
        send(c);
    endtask

    task automatic wait_end(input string name);
        int t = 0;
        while (t < 3000 && !(exp_q.size() == 0 && (load_done || load_error))) begin
            tick();
            t++;
        end
        check1({name, "_finished"}, (t < 3000), 1'b1);
        repeat (3) tick();
        check64({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_flags(input string name, input bit done, input bit err);
        check1({name, "_done"}, load_done, done);
        check1({name, "_err"}, load_error, err);
        check1({name, "_core_rst"}, core_rst, !done);
    endtask

    initial begin
        bq_t p;
        wr_t e;
        bit  bad, berr;
        int  n;

        tick();
        do_reset("reset0");

        // 16 bytes 00..0F, pinned literal writes
        p = {};
        for (int i = 0; i < 16; i++) p.push_back(8'(i));
        e.addr = BASE;        e.data = 64'h0706050403020100; e.strb = 8'hFF; exp_q.push_back(e);
        e.addr = BASE + 64'd8; e.data = 64'h0F0E0D0C0B0A0908; e.strb = 8'hFF; exp_q.push_back(e);
        send_frame(p, 1'b0, 0);
        wait_end("len16");
        check_flags("len16", 1'b1, 1'b0);
        send_frame(p, 1'b1, 0);
        repeat (20) tick();
        check_flags("run_ignores", 1'b1, 1'b0);

        // 3-byte partial word
        do_reset("reset1");
        p = '{8'h11, 8'h22, 8'h33};
        e.addr = BASE; e.data = 64'h0000000000332211; e.strb = 8'h07; exp_q.push_back(e);
        send_frame(p, 1'b0, 1);
        wait_end("len3");
        check_flags("len3", 1'b1, 1'b0);

        // Wrong checksum then a good frame
        do_reset("reset2");
        p = rand_payload(8, 1'b0);
        model_writes(p, 1000);
        send_frame(p, 1'b1, 1);
        wait_end("badchk");
        check_flags("badchk", 1'b0, 1'b1);
        p = rand_payload($urandom_range(1, 20), 1'b0);
        model_writes(p, 1000);
        send_frame(p, 1'b0, 1);
        wait_end("after_badchk");
        check_flags("after_badchk", 1'b1, 1'b0);

        // Oversize length: 65537
        do_reset("reset3");
        send(MAGIC); send(8'h01); send(8'h00); send(8'h01); send(8'h00);
        check1("oversize_err", load_error, 1'b1);
        repeat (20) tick();
        check_flags("oversize", 1'b0, 1'b1);
        p = rand_payload(10, 1'b0);
        model_writes(p, 1000);
        send_frame(p, 1'b0, 0);
        wait_end("after_oversize");
        check_flags("after_oversize", 1'b1, 1'b0);

        // Back-pressure, three words: overflow, only the in-flight word is written
        do_reset("reset4");
        ready_mode = 2;
        hold_cycles = 200;
        p = rand_payload(24, 1'b1);
        model_writes(p, 1);
        send_frame(p, 1'b0, 0);
        tick();
        check1("overflow_err", load_error, 1'b1);
        check1("overflow_no_done", load_done, 1'b0);
        wait_end("overflow");
        check_flags("overflow", 1'b0, 1'b1);
        ready_mode = 0;
        p = rand_payload(13, 1'b0);
        model_writes(p, 1000);
        send_frame(p, 1'b0, 0);
        wait_end("after_overflow");
        check_flags("after_overflow", 1'b1, 1'b0);

        // Back-pressure, two words: no error, writes in order
        do_reset("reset5");
        ready_mode = 2;
        hold_cycles = 200;
        p = rand_payload(16, 1'b0);
        model_writes(p, 1000);
        send_frame(p, 1'b0, 0);
        tick();
        check1("two_pending_no_err", load_error, 1'b0);
        wait_end("two_pending");
        check_flags("two_pending", 1'b1, 1'b0);

        // Error response on the first write
        do_reset("reset6");
        bresp_err_first = 1'b1;
        p = rand_payload(12, 1'b0);
        model_writes(p, 1000);
        send_frame(p, 1'b0, 1);
        wait_end("bresp_err");
        check_flags("bresp_err", 1'b0, 1'b1);

        // Reset mid-payload, then recovery
        do_reset("reset7");
        ready_mode = 1;
        p = rand_payload(40, 1'b0);
        model_writes(p, 1000);
        send_head(40);
        for (int i = 0; i < 20; i++) send(p[i]);
        do_reset("mid_rst");
        p = rand_payload(9, 1'b0);
        model_writes(p, 1000);
        send_frame(p, 1'b0, 0);
        wait_end("after_mid_rst");
        check_flags("after_mid_rst", 1'b1, 1'b0);

        // Random frames
        for (int it = 0; it < 10; it++) begin
            do_reset("reset_rand");
            ready_mode = int'($urandom_range(0, 1));
            n    = int'($urandom_range(0, 40));
            bad  = ($urandom_range(0, 3) == 0);
            berr = (n > 0) && ($urandom_range(0, 4) == 0);
            bresp_err_first = berr;
            p = rand_payload(n, 1'b0);
            model_writes(p, 1000);
            send_frame(p, bad, 2);
            wait_end("rand");
            check_flags("rand", !(bad || berr), bad || berr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
